// File: rtl/sccb_seq_pkg.sv
// Shared types and constants for the SCCB register sequencer: FSM states,
// table marker words, byte-step indices and the per-byte command bundle.
package sccb_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_WR,
        S_DELAY,
        S_NEXT,
        S_HOST,
        S_ABORT,
        S_DONE
    } seq_state_t;

    localparam logic [15:0] TBL_END = 16'hFFFF;
    localparam logic [15:0] TBL_DLY = 16'hFFF0;

    localparam logic [1:0] STEP_DEV  = 2'd0;
    localparam logic [1:0] STEP_REG  = 2'd1;
    localparam logic [1:0] STEP_DATA = 2'd2;
    localparam logic [1:0] STEP_READ = 2'd3;

    typedef struct packed {
        logic       start;
        logic       stop;
        logic       read;
        logic       write;
        logic       ack_in;
        logic [7:0] din;
    } byte_cmd_t;

    localparam byte_cmd_t CMD_STOP_ONLY = '{start: 1'b0, stop: 1'b1, read: 1'b0,
                                            write: 1'b0, ack_in: 1'b1, din: 8'h00};

    // Byte command for a given step; a host read turns step 1 into write+stop
    // and adds a repeated-start address phase and a NACKed read.
    function automatic byte_cmd_t step_cmd(input logic [6:0] dev, input logic is_rd,
                                           input logic [1:0] step, input logic [7:0] reg_a,
                                           input logic [7:0] val);
        byte_cmd_t c;
        c = '{start: 1'b0, stop: 1'b0, read: 1'b0, write: 1'b1, ack_in: 1'b1, din: {dev, 1'b0}};
        case (step)
            STEP_DEV:  c.start = 1'b1;
            STEP_REG: begin
                c.din  = reg_a;
                c.stop = is_rd;
            end
            STEP_DATA: begin
                if (is_rd) begin
                    c.start = 1'b1;
                    c.din   = {dev, 1'b1};
                end else begin
                    c.din  = val;
                    c.stop = 1'b1;
                end
            end
            default: begin
                c.write = 1'b0;
                c.read  = 1'b1;
                c.stop  = 1'b1;
                c.din   = 8'h00;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sccb_byte_issuer.sv
// Presents one byte command to the I2C byte controller, holds it until cmd_ack,
// drops it in the ack cycle and reports completion and write NACKs.
module sccb_byte_issuer
    import sccb_seq_pkg::*;
(
    input  logic       clk,
    input  logic       nReset,
    input  logic       i_rst,
    input  logic       i_go,
    input  byte_cmd_t  i_cmd,
    input  logic       i_cmd_ack,
    input  logic       i_ack_out,
    output logic       o_start,
    output logic       o_stop,
    output logic       o_read,
    output logic       o_write,
    output logic       o_ack_in,
    output logic [7:0] o_din,
    output logic       o_done,
    output logic       o_nack
);

    logic       r_active;
    logic       r_start, r_stop, r_read, r_write, r_ack_in;
    logic [7:0] r_din;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_active <= 1'b0;
            r_start  <= 1'b0;
            r_stop   <= 1'b0;
            r_read   <= 1'b0;
            r_write  <= 1'b0;
            r_ack_in <= 1'b1;
            r_din    <= 8'h00;
        end else if (i_rst) begin
            r_active <= 1'b0;
            r_start  <= 1'b0;
            r_stop   <= 1'b0;
            r_read   <= 1'b0;
            r_write  <= 1'b0;
            r_ack_in <= 1'b1;
            r_din    <= 8'h00;
        end else if (r_active && i_cmd_ack) begin
            // Drop the go bits at once so the controller never sees a re-issue.
            r_active <= 1'b0;
            r_start  <= 1'b0;
            r_stop   <= 1'b0;
            r_read   <= 1'b0;
            r_write  <= 1'b0;
        end else if (i_go && !r_active) begin
            r_active <= 1'b1;
            r_start  <= i_cmd.start;
            r_stop   <= i_cmd.stop;
            r_read   <= i_cmd.read;
            r_write  <= i_cmd.write;
            r_ack_in <= i_cmd.ack_in;
            r_din    <= i_cmd.din;
        end
    end

    assign o_start  = r_start;
    assign o_stop   = r_stop;
    assign o_read   = r_read;
    assign o_write  = r_write;
    assign o_ack_in = r_ack_in;
    assign o_din    = r_din;
    assign o_done   = r_active && i_cmd_ack;
    assign o_nack   = o_done && i_ack_out && r_write;

endmodule

// File: rtl/sccb_reg_sequencer.sv
// Walks a {reg, val} table into an OV7670-class camera over SCCB and
// arbitrates one host register port against the walk.
module sccb_reg_sequencer
    import sccb_seq_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR = 7'h21,
    parameter int          TBL_AW     = 8,
    parameter logic [19:0] DELAY_CYC  = 20'd500000,
    parameter bit          CHECK_ACK  = 1'b1
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              i_rst,
    input  logic              i_cfg_go,
    output logic [TBL_AW-1:0] o_tbl_addr,
    input  logic [15:0]       i_tbl_data,
    input  logic              i_host_req,
    input  logic              i_host_we,
    input  logic [7:0]        i_host_reg,
    input  logic [7:0]        i_host_wdata,
    output logic              o_host_ack,
    output logic [7:0]        o_host_rdata,
    output logic              o_busy,
    output logic              o_cfg_done,
    output logic              o_nack_err,
    output logic [TBL_AW-1:0] o_err_index,
    output logic              o_start,
    output logic              o_stop,
    output logic              o_read,
    output logic              o_write,
    output logic              o_ack_in,
    output logic [7:0]        o_din,
    input  logic              i_cmd_ack,
    input  logic              i_ack_out,
    input  logic [7:0]        i_dout
);

    localparam logic [TBL_AW-1:0] ADDR_ONE = {{(TBL_AW-1){1'b0}}, 1'b1};

    seq_state_t        r_state, w_state_nxt;
    logic [1:0]        r_step, w_step_nxt;
    logic              r_issued, w_issued_nxt;
    logic [TBL_AW-1:0] r_tbl_addr, w_tbl_addr_nxt;
    logic [7:0]        r_reg, w_reg_nxt;
    logic [7:0]        r_val, w_val_nxt;
    logic [19:0]       r_dly_cnt, w_dly_cnt_nxt;
    logic              r_pending, w_pending_nxt;
    logic              r_in_host, w_in_host_nxt;
    logic              r_host_rd, w_host_rd_nxt;
    logic              r_resume, w_resume_nxt;
    logic              r_host_block, w_host_block_nxt;
    logic              r_cfg_done, w_cfg_done_nxt;
    logic              r_nack_err, w_nack_err_nxt;
    logic [TBL_AW-1:0] r_err_index, w_err_index_nxt;
    logic              r_host_ack, w_host_ack_nxt;
    logic [7:0]        r_host_rdata, w_host_rdata_nxt;

    logic              w_go, w_bdone, w_bnack, w_host_ok;
    logic [1:0]        w_last_step;
    byte_cmd_t         w_cmd;

    sccb_byte_issuer u_issuer (
        .clk       (clk),
        .nReset    (nReset),
        .i_rst     (i_rst),
        .i_go      (w_go),
        .i_cmd     (w_cmd),
        .i_cmd_ack (i_cmd_ack),
        .i_ack_out (i_ack_out),
        .o_start   (o_start),
        .o_stop    (o_stop),
        .o_read    (o_read),
        .o_write   (o_write),
        .o_ack_in  (o_ack_in),
        .o_din     (o_din),
        .o_done    (w_bdone),
        .o_nack    (w_bnack)
    );

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state      <= S_IDLE;
            r_step       <= STEP_DEV;
            r_issued     <= 1'b0;
            r_tbl_addr   <= '0;
            r_reg        <= 8'h00;
            r_val        <= 8'h00;
            r_dly_cnt    <= 20'd0;
            r_pending    <= 1'b0;
            r_in_host    <= 1'b0;
            r_host_rd    <= 1'b0;
            r_resume     <= 1'b0;
            r_host_block <= 1'b0;
            r_cfg_done   <= 1'b0;
            r_nack_err   <= 1'b0;
            r_err_index  <= '0;
            r_host_ack   <= 1'b0;
            r_host_rdata <= 8'h00;
        end else if (i_rst) begin
            r_state      <= S_IDLE;
            r_step       <= STEP_DEV;
            r_issued     <= 1'b0;
            r_tbl_addr   <= '0;
            r_reg        <= 8'h00;
            r_val        <= 8'h00;
            r_dly_cnt    <= 20'd0;
            r_pending    <= 1'b0;
            r_in_host    <= 1'b0;
            r_host_rd    <= 1'b0;
            r_resume     <= 1'b0;
            r_host_block <= 1'b0;
            r_cfg_done   <= 1'b0;
            r_nack_err   <= 1'b0;
            r_err_index  <= '0;
            r_host_ack   <= 1'b0;
            r_host_rdata <= 8'h00;
        end else begin
            r_state      <= w_state_nxt;
            r_step       <= w_step_nxt;
            r_issued     <= w_issued_nxt;
            r_tbl_addr   <= w_tbl_addr_nxt;
            r_reg        <= w_reg_nxt;
            r_val        <= w_val_nxt;
            r_dly_cnt    <= w_dly_cnt_nxt;
            r_pending    <= w_pending_nxt;
            r_in_host    <= w_in_host_nxt;
            r_host_rd    <= w_host_rd_nxt;
            r_resume     <= w_resume_nxt;
            r_host_block <= w_host_block_nxt;
            r_cfg_done   <= w_cfg_done_nxt;
            r_nack_err   <= w_nack_err_nxt;
            r_err_index  <= w_err_index_nxt;
            r_host_ack   <= w_host_ack_nxt;
            r_host_rdata <= w_host_rdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_step_nxt       = r_step;
        w_issued_nxt     = r_issued;
        w_tbl_addr_nxt   = r_tbl_addr;
        w_reg_nxt        = r_reg;
        w_val_nxt        = r_val;
        w_dly_cnt_nxt    = r_dly_cnt;
        w_pending_nxt    = r_pending;
        w_in_host_nxt    = r_in_host;
        w_host_rd_nxt    = r_host_rd;
        w_resume_nxt     = r_resume;
        // A served request must be seen low once before it is accepted again.
        w_host_block_nxt = r_host_block && i_host_req;
        w_cfg_done_nxt   = r_cfg_done;
        w_nack_err_nxt   = r_nack_err;
        w_err_index_nxt  = r_err_index;
        w_host_ack_nxt   = 1'b0;
        w_host_rdata_nxt = r_host_rdata;
        w_host_ok        = i_host_req && !r_host_block;
        w_last_step      = (r_in_host && r_host_rd) ? STEP_READ : STEP_DATA;
        w_cmd            = step_cmd(SLAVE_ADDR, r_in_host && r_host_rd, r_step, r_reg, r_val);
        w_go             = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_host_ok) begin
                    w_state_nxt      = S_HOST;
                    w_step_nxt       = STEP_DEV;
                    w_issued_nxt     = 1'b0;
                    w_in_host_nxt    = 1'b1;
                    w_host_rd_nxt    = !i_host_we;
                    w_reg_nxt        = i_host_reg;
                    w_val_nxt        = i_host_wdata;
                    w_host_block_nxt = 1'b1;
                    w_nack_err_nxt   = 1'b0;
                    w_resume_nxt     = 1'b0;
                    w_pending_nxt    = r_pending || i_cfg_go;
                end else if (i_cfg_go || r_pending) begin
                    w_state_nxt    = S_FETCH;
                    w_tbl_addr_nxt = '0;
                    w_cfg_done_nxt = 1'b0;
                    w_nack_err_nxt = 1'b0;
                    w_pending_nxt  = 1'b0;
                end
            end
            S_FETCH: w_state_nxt = S_DECODE;
            S_DECODE: begin
                w_reg_nxt = i_tbl_data[15:8];
                w_val_nxt = i_tbl_data[7:0];
                if (i_tbl_data == TBL_END) begin
                    w_state_nxt = S_DONE;
                end else if (i_tbl_data == TBL_DLY) begin
                    w_state_nxt   = S_DELAY;
                    w_dly_cnt_nxt = 20'd0;
                end else begin
                    w_state_nxt  = S_WR;
                    w_step_nxt   = STEP_DEV;
                    w_issued_nxt = 1'b0;
                end
            end
            S_WR, S_HOST: begin
                w_go = !r_issued;
                if (!r_issued) w_issued_nxt = 1'b1;
                if (w_bdone) begin
                    w_issued_nxt = 1'b0;
                    if (w_bnack && CHECK_ACK) begin
                        w_state_nxt = S_ABORT;
                    end else if (r_step == w_last_step) begin
                        if (r_state == S_WR) begin
                            w_state_nxt = S_NEXT;
                        end else begin
                            w_host_ack_nxt = 1'b1;
                            w_in_host_nxt  = 1'b0;
                            if (r_host_rd) w_host_rdata_nxt = i_dout;
                            w_state_nxt = r_resume ? S_FETCH : S_IDLE;
                        end
                    end else begin
                        w_step_nxt = r_step + 2'd1;
                    end
                end
            end
            S_DELAY: begin
                if (r_dly_cnt == DELAY_CYC - 20'd1) w_state_nxt = S_NEXT;
                else                                w_dly_cnt_nxt = r_dly_cnt + 20'd1;
            end
            S_NEXT: begin
                w_tbl_addr_nxt = r_tbl_addr + ADDR_ONE;
                if (&r_tbl_addr) begin
                    w_state_nxt = S_DONE;
                end else if (w_host_ok) begin
                    w_state_nxt      = S_HOST;
                    w_step_nxt       = STEP_DEV;
                    w_issued_nxt     = 1'b0;
                    w_in_host_nxt    = 1'b1;
                    w_host_rd_nxt    = !i_host_we;
                    w_reg_nxt        = i_host_reg;
                    w_val_nxt        = i_host_wdata;
                    w_host_block_nxt = 1'b1;
                    w_nack_err_nxt   = 1'b0;
                    w_resume_nxt     = 1'b1;
                end else begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_ABORT: begin
                w_cmd = CMD_STOP_ONLY;
                w_go  = !r_issued;
                if (!r_issued) w_issued_nxt = 1'b1;
                if (w_bdone) begin
                    w_issued_nxt   = 1'b0;
                    w_nack_err_nxt = 1'b1;
                    if (r_in_host) begin
                        w_host_ack_nxt = 1'b1;
                        w_in_host_nxt  = 1'b0;
                        w_state_nxt    = r_resume ? S_FETCH : S_IDLE;
                    end else begin
                        w_err_index_nxt = r_tbl_addr;
                        w_cfg_done_nxt  = 1'b0;
                        w_state_nxt     = S_IDLE;
                    end
                end
            end
            S_DONE: begin
                w_cfg_done_nxt = 1'b1;
                w_state_nxt    = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_tbl_addr   = r_tbl_addr;
    assign o_host_ack   = r_host_ack;
    assign o_host_rdata = r_host_rdata;
    assign o_busy       = (r_state != S_IDLE);
    assign o_cfg_done   = r_cfg_done;
    assign o_nack_err   = r_nack_err;
    assign o_err_index  = r_err_index;

endmodule

// File: tb/tb_sccb_reg_sequencer.sv
// Directed bench for sccb_reg_sequencer: a byte-controller model logs every
// command and acks it; table walks, delay, NACK abort, host access and reset.
module tb_sccb_reg_sequencer;

    localparam int TBL_AW = 8;

    logic              clk = 1'b0;
    logic              nReset = 1'b0;
    logic              i_rst = 1'b0;
    logic              cfg_go = 1'b0;
    logic [TBL_AW-1:0] tbl_addr;
    logic [15:0]       tbl_data;
    logic              host_req = 1'b0;
    logic              host_we = 1'b0;
    logic [7:0]        host_reg = 8'h00;
    logic [7:0]        host_wdata = 8'h00;
    logic              host_ack;
    logic [7:0]        host_rdata;
    logic              busy, cfg_done, nack_err;
    logic [TBL_AW-1:0] err_index;
    logic              start, stop, read, write, ack_in;
    logic [7:0]        din;
    logic              cmd_ack = 1'b0;
    logic              ack_out = 1'b0;
    logic [7:0]        dout = 8'h00;

    logic [15:0] tbl [256];
    assign tbl_data = tbl[tbl_addr];

    always #5 clk = ~clk;

    sccb_reg_sequencer #(
        .SLAVE_ADDR (7'h21),
        .TBL_AW     (TBL_AW),
        .DELAY_CYC  (20'd100),
        .CHECK_ACK  (1'b1)
    ) dut (
        .clk          (clk),
        .nReset       (nReset),
        .i_rst        (i_rst),
        .i_cfg_go     (cfg_go),
        .o_tbl_addr   (tbl_addr),
        .i_tbl_data   (tbl_data),
        .i_host_req   (host_req),
        .i_host_we    (host_we),
        .i_host_reg   (host_reg),
        .i_host_wdata (host_wdata),
        .o_host_ack   (host_ack),
        .o_host_rdata (host_rdata),
        .o_busy       (busy),
        .o_cfg_done   (cfg_done),
        .o_nack_err   (nack_err),
        .o_err_index  (err_index),
        .o_start      (start),
        .o_stop       (stop),
        .o_read       (read),
        .o_write      (write),
        .o_ack_in     (ack_in),
        .o_din        (din),
        .i_cmd_ack    (cmd_ack),
        .i_ack_out    (ack_out),
        .i_dout       (dout)
    );

    // Command log: ctl = {start, stop, read, write}
    localparam logic [3:0] C_SW = 4'b1001, C_W = 4'b0001, C_WS = 4'b0101,
                           C_RS = 4'b0110, C_S = 4'b0100;
    logic [3:0] log_ctl   [64];
    logic [7:0] log_din   [64];
    logic       log_ackin [64];
    int         log_cyc   [64];
    int         ack_cyc   [64];
    int         nlog = 0;
    int         cyc = 0;
    int         nack_at = -1;
    logic [7:0] rd_byte = 8'h00;
    bit         m_pend = 1'b0;
    int         m_cnt = 0;
    int         unstable = 0;
    int         n_hack = 0;

    int n_vec = 0;
    int n_miss = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) if (host_ack) n_hack++;

    // Byte-controller model: 3-cycle latency per command, NACKs log index nack_at.
    always @(negedge clk) begin
        cmd_ack = 1'b0;
        ack_out = 1'b0;
        if (!nReset) begin
            m_pend = 1'b0;
        end else if (m_pend) begin
            if ({start, stop, read, write} != log_ctl[nlog-1] || din != log_din[nlog-1])
                unstable++;
            m_cnt--;
            if (m_cnt == 0) begin
                cmd_ack = 1'b1;
                ack_out = (nack_at == nlog - 1);
                dout    = rd_byte;
                ack_cyc[nlog-1] = cyc;
                m_pend  = 1'b0;
            end
        end else if ((start || stop || read || write) && nlog < 64) begin
            log_ctl[nlog]   = {start, stop, read, write};
            log_din[nlog]   = din;
            log_ackin[nlog] = ack_in;
            log_cyc[nlog]   = cyc;
            nlog++;
            m_pend = 1'b1;
            m_cnt  = 3;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_byte(input string tag, input int i, input logic [3:0] ctl,
                            input logic [7:0] d);
        chk($sformatf("%s b%0d", tag, i), 32'({log_ctl[i], log_din[i]}), 32'({ctl, d}));
    endtask

    task automatic new_test();
        for (int i = 0; i < 256; i++) tbl[i] = 16'hFFFF;
        for (int i = 0; i < 64; i++) begin
            log_ctl[i] = 4'h0;
            log_din[i] = 8'h00;
        end
        nlog    = 0;
        nack_at = -1;
        n_hack  = 0;
    endtask

    task automatic pulse_go();
        @(negedge clk);
        cfg_go = 1'b1;
        @(negedge clk);
        cfg_go = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " idle"}, 32'(busy), 32'h0);
    endtask

    task automatic wait_nlog(input string tag, input int target);
        int n;
        n = 0;
        while (nlog < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " reached"}, 32'(nlog >= target), 32'h1);
    endtask

    task automatic wait_hack(input string tag);
        int n;
        n = 0;
        while (n_hack == 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " host_ack seen"}, 32'(n_hack > 0), 32'h1);
    endtask

    initial begin
        new_test();
        repeat (3) @(negedge clk);
        chk("rst cmds",  32'({start, stop, read, write}), 32'h0);
        chk("rst ackin", 32'(ack_in), 32'h1);
        nReset = 1'b1;
        @(negedge clk);
        chk("rst busy",  32'(busy), 32'h0);
        chk("rst flags", 32'({cfg_done, nack_err, host_ack}), 32'h0);
        chk("rst addr",  32'(tbl_addr), 32'h0);
        chk("rst rdata", 32'(host_rdata), 32'h0);

        // single entry walk
        new_test();
        tbl[0] = 16'h1280;
        pulse_go();
        wait_idle("t1");
        chk("t1 nlog", 32'(nlog), 32'd3);
        chk_byte("t1", 0, C_SW, 8'h42);
        chk_byte("t1", 1, C_W,  8'h12);
        chk_byte("t1", 2, C_WS, 8'h80);
        chk("t1 done", 32'(cfg_done), 32'h1);
        chk("t1 nack", 32'(nack_err), 32'h0);

        // delay entry between two writes
        new_test();
        tbl[0] = 16'h1180; tbl[1] = 16'hFFF0; tbl[2] = 16'h3A04;
        pulse_go();
        wait_idle("t2");
        chk("t2 nlog", 32'(nlog), 32'd6);
        chk_byte("t2", 2, C_WS, 8'h80);
        chk_byte("t2", 3, C_SW, 8'h42);
        chk_byte("t2", 4, C_W,  8'h3A);
        chk_byte("t2", 5, C_WS, 8'h04);
        chk("t2 gap min", 32'((log_cyc[3] - ack_cyc[2]) >= 100), 32'h1);
        chk("t2 gap max", 32'((log_cyc[3] - ack_cyc[2]) <= 110), 32'h1);
        chk("t2 done", 32'(cfg_done), 32'h1);

        // NACK on entry 2 byte 1
        new_test();
        tbl[0] = 16'h1111; tbl[1] = 16'h2222; tbl[2] = 16'h3333; tbl[3] = 16'h4444;
        nack_at = 7;
        pulse_go();
        wait_idle("t3");
        chk("t3 nlog", 32'(nlog), 32'd9);
        chk_byte("t3", 7, C_W, 8'h33);
        chk("t3 stop only", 32'(log_ctl[8]), 32'(C_S));
        chk("t3 nack", 32'(nack_err), 32'h1);
        chk("t3 eidx", 32'(err_index), 32'h2);
        chk("t3 done", 32'(cfg_done), 32'h0);

        // host read of reg 0x0A, request held past ack
        new_test();
        rd_byte = 8'h76;
        @(negedge clk);
        host_we = 1'b0; host_reg = 8'h0A; host_req = 1'b1;
        wait_hack("t4");
        repeat (20) @(negedge clk);
        chk("t4 nlog", 32'(nlog), 32'd4);
        chk("t4 hack count", 32'(n_hack), 32'd1);
        host_req = 1'b0;
        wait_idle("t4");
        chk_byte("t4", 0, C_SW, 8'h42);
        chk_byte("t4", 1, C_WS, 8'h0A);
        chk_byte("t4", 2, C_SW, 8'h43);
        chk("t4 rd ctl", 32'(log_ctl[3]), 32'(C_RS));
        chk("t4 rd ackin", 32'(log_ackin[3]), 32'h1);
        chk("t4 rdata", 32'(host_rdata), 32'h76);
        chk("t4 nack cleared", 32'(nack_err), 32'h0);

        // host write injected during entry 1
        new_test();
        tbl[0] = 16'h1101; tbl[1] = 16'h2202; tbl[2] = 16'h3303;
        pulse_go();
        wait_nlog("t5", 4);
        host_we = 1'b1; host_reg = 8'h55; host_wdata = 8'h66; host_req = 1'b1;
        wait_hack("t5");
        host_req = 1'b0;
        wait_idle("t5");
        chk("t5 nlog", 32'(nlog), 32'd12);
        chk_byte("t5", 4, C_W,  8'h22);
        chk_byte("t5", 5, C_WS, 8'h02);
        chk_byte("t5", 6, C_SW, 8'h42);
        chk_byte("t5", 7, C_W,  8'h55);
        chk_byte("t5", 8, C_WS, 8'h66);
        chk_byte("t5", 10, C_W, 8'h33);
        chk_byte("t5", 11, C_WS, 8'h03);
        chk("t5 hack count", 32'(n_hack), 32'd1);
        chk("t5 done", 32'(cfg_done), 32'h1);

        // async reset in the middle of entry 1 step 1
        new_test();
        tbl[0] = 16'h1101; tbl[1] = 16'h2202; tbl[2] = 16'h3303;
        pulse_go();
        wait_nlog("t6", 5);
        @(negedge clk);
        nReset = 1'b0;
        #1;
        chk("t6 cmds", 32'({start, stop, read, write}), 32'h0);
        chk("t6 ackin", 32'(ack_in), 32'h1);
        chk("t6 addr", 32'(tbl_addr), 32'h0);
        chk("t6 busy", 32'(busy), 32'h0);
        @(negedge clk);
        nReset = 1'b1;
        repeat (2) @(negedge clk);
        new_test();
        tbl[0] = 16'h1101; tbl[1] = 16'h2202; tbl[2] = 16'h3303;
        pulse_go();
        wait_idle("t6");
        chk("t6 nlog", 32'(nlog), 32'd9);
        chk_byte("t6", 1, C_W, 8'h11);
        chk("t6 done", 32'(cfg_done), 32'h1);

        chk("cmd stable", 32'(unstable), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
